// File: rtl/engine_reg_pkg.sv
// engine_reg_pkg
//   Shared definitions for the Engine control-register bus arbiter:
//   default bus widths and the arbiter FSM state type.
package engine_reg_pkg;

    localparam int ENGINE_ADDR_W  = 33;
    localparam int ENGINE_DATA_W  = 33;
    localparam int ENGINE_RDATA_W = 21;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/engine_rr_pick.sv
// engine_rr_pick
//   Combinational rotate-priority picker. Scans req starting at ptr and
//   wrapping modulo N; returns the first set request as a one-hot grant and
//   as an index.
//   Ports:
//     req  in  N      request vector
//     ptr  in  PTR_W  scan start position (0..N-1)
//     gnt  out N      one-hot grant, 0 when no request
//     idx  out PTR_W  index of the granted request
//     any  out 1      some request was found
module engine_rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    localparam logic [PTR_W:0] NW  = (PTR_W+1)'(N);
    localparam logic [N-1:0]   ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] rot;
    logic [PTR_W:0] pos;

    always_comb begin
        // Doubling the vector turns the wrap-around scan into a plain shift:
        // rot[k] is req[(ptr+k) mod N].
        rot = N'({req, req} >> ptr);
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = 0; k < N; k++) begin
            if (!any && rot[k]) begin
                any = 1'b1;
                pos = {1'b0, ptr} + (PTR_W+1)'(k);
                if (pos >= NW) pos = pos - NW;
                idx = pos[PTR_W-1:0];
            end
        end
        if (any) gnt = ONE << idx;
    end

endmodule

// File: rtl/engine_reg_bus_arbiter.sv
// engine_reg_bus_arbiter
//   Round-robin arbiter sharing the Engine control-register bus between
//   NUM_MASTERS requesters. Each access takes three cycles:
//   IDLE (grant/accept) -> ACCESS (register strobe) -> RESP (done + rdata).
//   Optional feature: define ENGINE_ARB_LOCK_EN to let a master hold the
//   bus across a read-modify-write via m_lock; otherwise m_lock is ignored.
//   Ports:
//     clock, reset          rising-edge clock, synchronous active-high reset
//     m_req/m_we/m_lock     per-master request, write flag, lock request
//     m_addr/m_wdata        packed per-master payload, master i at [i*W +: W]
//     m_gnt                 combinational one-hot accept (IDLE only)
//     m_done/m_rdata        registered completion pulse and read return
//     address/write_enable/write_data/read_enable  register block strobes
//     read_data             combinational read data from register block
module engine_reg_bus_arbiter
    import engine_reg_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = ENGINE_ADDR_W,
    parameter int DATA_W      = ENGINE_DATA_W,
    parameter int RDATA_W     = ENGINE_RDATA_W
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS-1:0]        m_we,
    input  logic [NUM_MASTERS-1:0]        m_lock,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]        m_gnt,
    output logic [NUM_MASTERS-1:0]        m_done,
    output logic [RDATA_W-1:0]            m_rdata,
    output logic [ADDR_W-1:0]             address,
    output logic                          write_enable,
    output logic [DATA_W-1:0]             write_data,
    output logic                          read_enable,
    input  logic [RDATA_W-1:0]            read_data
);

    localparam int PTR_W = $clog2(NUM_MASTERS);

    arb_state_t             state;
    logic [PTR_W-1:0]       ptr;
    logic [NUM_MASTERS-1:0] done_sel;   // one-hot owner of the in-flight access

    logic [NUM_MASTERS-1:0] elig;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [PTR_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   accept;

    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_wdata;
    logic                   sel_we;
    logic                   sel_lock;

`ifdef ENGINE_ARB_LOCK_EN
    logic                   lock_q;
    logic [NUM_MASTERS-1:0] lock_owner;

    // While locked, only the owner can win; others keep waiting.
    assign elig = lock_q ? (m_req & lock_owner) : m_req;
`else
    logic unused_lock;

    assign elig        = m_req;
    assign unused_lock = ^{m_lock, sel_lock};
`endif

    engine_rr_pick #(
        .N     (NUM_MASTERS),
        .PTR_W (PTR_W)
    ) u_pick (
        .req (elig),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign m_gnt  = (state == IDLE && !reset) ? pick_gnt : '0;
    assign accept = pick_any && (state == IDLE) && !reset;

    // Winner payload mux.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        sel_lock  = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick_gnt[i]) begin
                sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = m_wdata[i*DATA_W +: DATA_W];
                sel_we    = m_we[i];
                sel_lock  = m_lock[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            done_sel     <= '0;
            address      <= '0;
            write_data   <= '0;
            write_enable <= 1'b0;
            read_enable  <= 1'b0;
            m_done       <= '0;
            m_rdata      <= '0;
`ifdef ENGINE_ARB_LOCK_EN
            lock_q       <= 1'b0;
            lock_owner   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    m_done  <= '0;
                    m_rdata <= '0;
                    if (accept) begin
                        state        <= ACCESS;
                        ptr          <= (pick_idx == PTR_W'(NUM_MASTERS-1)) ? '0 : pick_idx + 1'b1;
                        done_sel     <= pick_gnt;
                        address      <= sel_addr;
                        write_data   <= sel_wdata;
                        write_enable <= sel_we;
                        read_enable  <= !sel_we;
`ifdef ENGINE_ARB_LOCK_EN
                        lock_q       <= sel_lock;
                        lock_owner   <= pick_gnt;
`endif
                    end
                end
                ACCESS: begin
                    state        <= RESP;
                    address      <= '0;
                    write_data   <= '0;
                    write_enable <= 1'b0;
                    read_enable  <= 1'b0;
                    m_done       <= done_sel;
                    // Writes return zero data.
                    m_rdata      <= read_enable ? read_data : '0;
                end
                RESP: begin
                    state   <= IDLE;
                    m_done  <= '0;
                    m_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_engine_reg_bus_arbiter.sv
// tb_engine_reg_bus_arbiter
//   Directed bench for engine_reg_bus_arbiter (4 masters, default widths).
//   Lock expectations follow ENGINE_ARB_LOCK_EN.
module tb_engine_reg_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 33;
    localparam int DW = 33;
    localparam int RW = 21;

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      m_req, m_we, m_lock;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_wdata;
    logic [N-1:0]      m_gnt, m_done;
    logic [RW-1:0]     m_rdata;
    logic [AW-1:0]     address;
    logic              write_enable, read_enable;
    logic [DW-1:0]     write_data;
    logic [RW-1:0]     read_data;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    engine_reg_bus_arbiter #(
        .NUM_MASTERS (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .RDATA_W     (RW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .m_req        (m_req),
        .m_we         (m_we),
        .m_lock       (m_lock),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_gnt        (m_gnt),
        .m_done       (m_done),
        .m_rdata      (m_rdata),
        .address      (address),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_enable  (read_enable),
        .read_data    (read_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_m(input int i, input logic req, input logic we, input logic lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_req[i]              = req;
        m_we[i]               = we;
        m_lock[i]             = lk;
        m_addr[i*AW +: AW]    = a;
        m_wdata[i*DW +: DW]   = d;
    endtask

    int e_first, e_second;
    logic [DW-1:0] d_first, d_second;

    initial begin
        reset = 1'b1; m_req = '0; m_we = '0; m_lock = '0;
        m_addr = '0; m_wdata = '0; read_data = '0;
        cyc(); cyc();

        // Reset: gnt forced 0 even with a request present, outputs 0.
        set_m(0, 1'b1, 1'b0, 1'b0, 33'h1, 33'h0);
        #1;
        check("rst_gnt",    64'(m_gnt), 64'(0));
        check("rst_addr",   64'(address), 64'(0));
        check("rst_strb",   64'({write_enable, read_enable, write_data}), 64'(0));
        check("rst_done",   64'({m_done, m_rdata}), 64'(0));
        set_m(0, 1'b0, 1'b0, 1'b0, 33'h0, 33'h0);
        reset = 1'b0;
        cyc();

        // Single read from master 2.
        set_m(2, 1'b1, 1'b0, 1'b0, 33'hAA, 33'h0);
        #1;
        check("rd_gnt", 64'(m_gnt), 64'(4'b0100));
        cyc();
        set_m(2, 1'b0, 1'b0, 1'b0, 33'h0, 33'h0);
        read_data = 21'h1234;
        check("rd_strb",      64'({write_enable, read_enable}), 64'(2'b01));
        check("rd_addr",      64'(address), 64'(33'hAA));
        check("rd_gnt_busy",  64'(m_gnt), 64'(0));
        cyc();
        check("rd_done",      64'(m_done), 64'(4'b0100));
        check("rd_rdata",     64'(m_rdata), 64'(21'h1234));
        check("rd_resp_strb", 64'({write_enable, read_enable, address}), 64'(0));
        cyc();
        check("rd_done_clr",  64'({m_done, m_rdata}), 64'(0));

        // All four masters writing continuously: order 0,1,2,3,0.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < N; i++)
            set_m(i, 1'b1, 1'b1, 1'b0, 33'h10 + 33'(i), 33'h100 + 33'(i));
        read_data = 21'h1FFFF;
        for (int g = 0; g < 5; g++) begin
            int ex;
            ex = g % N;
            #1;
            check("rr_gnt",   64'(m_gnt), 64'(4'b0001 << ex));
            cyc();
            check("rr_strb",  64'({write_enable, read_enable}), 64'(2'b10));
            check("rr_wdata", 64'(write_data), 64'(33'h100 + 33'(ex)));
            check("rr_addr",  64'(address), 64'(33'h10 + 33'(ex)));
            check("rr_gnt_busy", 64'(m_gnt), 64'(0));
            cyc();
            check("rr_done",  64'(m_done), 64'(4'b0001 << ex));
            check("rr_rdata_wr", 64'(m_rdata), 64'(0));
            check("rr_gnt_resp", 64'(m_gnt), 64'(0));
            cyc();
        end
        m_req = '0;

        // Reset during ACCESS (ptr=1 here, master 2 wins).
        set_m(2, 1'b1, 1'b0, 1'b0, 33'h33, 33'h0);
        #1;
        check("ra_gnt2", 64'(m_gnt), 64'(4'b0100));
        cyc();
        check("ra_strb", 64'(read_enable), 64'(1));
        reset = 1'b1;
        m_req = '0;
        set_m(1, 1'b1, 1'b0, 1'b0, 33'h21, 33'h0);
        set_m(3, 1'b1, 1'b0, 1'b0, 33'h23, 33'h0);
        #1;
        check("ra_gnt_inrst", 64'(m_gnt), 64'(0));
        cyc();
        check("ra_strb_drop", 64'({write_enable, read_enable, address}), 64'(0));
        check("ra_no_done",   64'({m_done, m_rdata}), 64'(0));
        reset = 1'b0;
        #1;
        check("ra_gnt1", 64'(m_gnt), 64'(4'b0010));
        cyc();
        m_req = '0;
        read_data = 21'h0ABC;
        check("ra_addr", 64'(address), 64'(33'h21));
        check("ra_no_done2", 64'(m_done), 64'(0));
        cyc();
        check("ra_done", 64'(m_done), 64'(4'b0010));
        check("ra_rdata", 64'(m_rdata), 64'(21'h0ABC));
        cyc();

        // Lock: master 1 read with m_lock=1, then its write; master 0 waits if locked.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        set_m(1, 1'b1, 1'b0, 1'b1, 33'h51, 33'h0);
        #1;
        check("lk_gnt_rd", 64'(m_gnt), 64'(4'b0010));
        cyc();
        set_m(1, 1'b1, 1'b1, 1'b0, 33'h52, 33'h77);
        set_m(0, 1'b1, 1'b1, 1'b0, 33'h40, 33'h44);
        read_data = 21'h0555;
        check("lk_rd_addr", 64'(address), 64'(33'h51));
        cyc();
        check("lk_rd_done", 64'({m_done, m_rdata}), 64'({4'b0010, 21'h0555}));
        cyc();
`ifdef ENGINE_ARB_LOCK_EN
        e_first = 1; d_first = 33'h77; e_second = 0; d_second = 33'h44;
`else
        e_first = 0; d_first = 33'h44; e_second = 1; d_second = 33'h77;
`endif
        #1;
        check("lk_gnt_first", 64'(m_gnt), 64'(4'b0001 << e_first));
        cyc();
        m_req[e_first] = 1'b0;
        check("lk_wdata_first", 64'(write_data), 64'(d_first));
        cyc();
        check("lk_done_first", 64'(m_done), 64'(4'b0001 << e_first));
        cyc();
        #1;
        check("lk_gnt_second", 64'(m_gnt), 64'(4'b0001 << e_second));
        cyc();
        m_req[e_second] = 1'b0;
        check("lk_wdata_second", 64'(write_data), 64'(d_second));
        cyc();
        check("lk_done_second", 64'({m_done, m_rdata}), 64'({4'b0001 << e_second, 21'h0}));
        cyc();

        // Idle bus for 20 cycles.
        m_req = '0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            check("idle_addr", 64'(address), 64'(0));
            check("idle_strb", 64'({write_enable, read_enable, m_gnt, m_done}), 64'(0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
